// File: rtl/trace_dump_unit_pkg.sv
// Shared definitions for the retirement-trace capture and dump engine:
// output beat tags, dump FSM states and trace-entry field widths.
package trace_dump_unit_pkg;

    // Beat tag field and its encodings
    localparam int W_TAG = 2;
    localparam logic [W_TAG-1:0] TAG_TRACE = 2'b00;
    localparam logic [W_TAG-1:0] TAG_REG   = 2'b01;
    localparam logic [W_TAG-1:0] TAG_MEM   = 2'b10;
    localparam logic [W_TAG-1:0] TAG_END   = 2'b11;

    // Destination register index and the {wr, reg} field carried by trace beats
    localparam int W_REG  = 4;
    localparam int W_TREG = W_REG + 1;

    // Dump FSM states
    typedef enum logic [2:0] {
        ST_CAPTURE  = 3'd0,
        ST_TRACE    = 3'd1,
        ST_REG      = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_END      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Packs the write flag and destination register into the trace-beat field
    function automatic logic [W_TREG-1:0] pack_treg(input logic wr, input logic [W_REG-1:0] rg);
        return {wr, rg};
    endfunction

endpackage

// File: rtl/trace_dump_unit_trace_ring.sv
// Circular trace buffer: push at the write pointer, pop from the read pointer.
// A push into a full ring overwrites the oldest entry and sets a sticky
// overflow flag that only reset clears.
module trace_ring #(
    parameter int DEPTH = 16,
    parameter int W     = 53
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow
);
    localparam int W_PTR = $clog2(DEPTH);
    localparam int W_CNT = $clog2(DEPTH+1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [W_PTR-1:0] r_wptr;
    logic [W_PTR-1:0] r_rptr;
    logic [W_CNT-1:0] r_count;
    logic             r_overflow;
    logic             w_pop;
    logic             w_overwrite;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == W_CNT'(DEPTH));
    assign w_pop       = i_pop && !o_empty;
    // A push into a full ring that is not simultaneously draining drops the oldest entry
    assign w_overwrite = i_push && o_full && !w_pop;
    assign o_head      = r_mem[r_rptr];
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;

    // Entry storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + W_PTR'(1);
            end
            if (w_pop || w_overwrite) begin
                r_rptr <= r_rptr + W_PTR'(1);
            end
            if (i_push && !w_pop && !o_full) begin
                r_count <= r_count + W_CNT'(1);
            end else if (w_pop && !i_push) begin
                r_count <= r_count - W_CNT'(1);
            end
            if (w_overwrite) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/trace_dump_unit.sv
// Retirement-trace capture and end-of-run dump engine. Captures retired
// instructions into a ring; on halt streams trace, register file, a data-memory
// window and an end marker through a single registered valid/ready beat.
module trace_dump_unit
    import trace_dump_unit_pkg::*;
#(
    parameter int W_PC      = 16,
    parameter int W_OPR     = 32,
    parameter int N_REG     = 16,
    parameter int DEPTH     = 16,
    parameter int ADDR      = 16,
    parameter int MEM_BASE  = 0,
    parameter int MEM_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_valid_i,
    input  logic              trace_wr_i,
    input  logic [W_REG-1:0]  trace_reg_i,
    input  logic [W_PC-1:0]   trace_pc_i,
    input  logic [W_OPR-1:0]  trace_result_i,
    input  logic              halt_i,
    output logic [W_REG-1:0]  reg_addr_o,
    input  logic [W_OPR-1:0]  reg_data_i,
    output logic [ADDR-1:0]   mem_addr_o,
    input  logic [W_OPR-1:0]  mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W_TAG-1:0]  out_tag_o,
    output logic [W_PC-1:0]   out_idx_o,
    output logic [W_TREG-1:0] out_reg_o,
    output logic [W_OPR-1:0]  out_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);
    localparam int W_ENT = W_PC + W_TREG + W_OPR;
    localparam int W_CNT = $clog2(DEPTH+1);
    localparam int K_MAX = (N_REG > MEM_WORDS) ? N_REG : MEM_WORDS;
    localparam int W_K   = $clog2(K_MAX+1);

    state_t             r_state;
    state_t             w_state_next;
    logic [W_K-1:0]     r_k;
    logic [W_K-1:0]     w_k_next;
    logic [W_CNT-1:0]   r_n_trace;

    // Output beat register
    logic               r_valid;
    logic [W_TAG-1:0]   r_tag;
    logic [W_PC-1:0]    r_idx;
    logic [W_TREG-1:0]  r_reg;
    logic [W_OPR-1:0]   r_data;

    // Next-beat load request from the FSM
    logic               w_load;
    logic [W_TAG-1:0]   w_ld_tag;
    logic [W_PC-1:0]    w_ld_idx;
    logic [W_TREG-1:0]  w_ld_reg;
    logic [W_OPR-1:0]   w_ld_data;

    logic               w_take;
    logic               w_push;
    logic               w_pop;
    logic [W_ENT-1:0]   w_push_data;
    logic [W_ENT-1:0]   w_head;
    logic [W_CNT-1:0]   w_ring_count;
    logic               w_ring_empty;
    logic               w_ring_full;
    logic               w_ring_overflow;
    logic [W_CNT-1:0]   w_n_trace;
    logic [W_REG-1:0]   w_reg_addr;
    logic [ADDR-1:0]    w_mem_addr;

    // The beat register can take a new beat when empty or when its beat leaves this cycle
    assign w_take      = !r_valid || out_ready_i;
    assign w_push_data = {trace_pc_i, pack_treg(trace_wr_i, trace_reg_i), trace_result_i};
    // A retirement coinciding with halt is counted as part of the trace
    assign w_n_trace   = w_ring_count + W_CNT'(trace_valid_i && !w_ring_full);

    trace_ring #(
        .DEPTH (DEPTH),
        .W     (W_ENT)
    ) u_ring (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_ring_count),
        .o_empty     (w_ring_empty),
        .o_full      (w_ring_full),
        .o_overflow  (w_ring_overflow)
    );

    // Dump FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, beat selection, ring control and read addresses
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_load       = 1'b0;
        w_ld_tag     = TAG_TRACE;
        w_ld_idx     = '0;
        w_ld_reg     = '0;
        w_ld_data    = '0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_reg_addr   = '0;
        w_mem_addr   = '0;
        unique case (r_state)
            ST_CAPTURE: begin
                w_push = trace_valid_i;
                if (halt_i) begin
                    w_k_next     = '0;
                    w_state_next = (!w_ring_empty || trace_valid_i) ? ST_TRACE : ST_REG;
                end
            end
            ST_TRACE: begin
                if (w_ring_empty) begin
                    w_state_next = ST_REG;
                end else if (w_take) begin
                    w_load    = 1'b1;
                    w_ld_tag  = TAG_TRACE;
                    w_ld_idx  = w_head[W_ENT-1 -: W_PC];
                    w_ld_reg  = w_head[W_OPR +: W_TREG];
                    w_ld_data = w_head[W_OPR-1:0];
                    w_pop     = 1'b1;
                    if (w_ring_count == W_CNT'(1)) begin
                        w_state_next = ST_REG;
                    end
                end
            end
            ST_REG: begin
                w_reg_addr = W_REG'(r_k);
                if (w_take) begin
                    w_load    = 1'b1;
                    w_ld_tag  = TAG_REG;
                    w_ld_idx  = W_PC'(r_k);
                    w_ld_data = reg_data_i;
                    if (r_k == W_K'(N_REG-1)) begin
                        w_k_next     = '0;
                        w_state_next = ST_MEM_REQ;
                    end else begin
                        w_k_next = r_k + W_K'(1);
                    end
                end
            end
            ST_MEM_REQ: begin
                w_mem_addr = ADDR'(MEM_BASE) + ADDR'(r_k);
                // Only issue the read once the beat register is guaranteed free next cycle
                if (w_take) begin
                    w_state_next = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                w_mem_addr = ADDR'(MEM_BASE) + ADDR'(r_k);
                w_load     = 1'b1;
                w_ld_tag   = TAG_MEM;
                w_ld_idx   = W_PC'(w_mem_addr);
                w_ld_data  = mem_data_i;
                if (r_k == W_K'(MEM_WORDS-1)) begin
                    w_k_next     = '0;
                    w_state_next = ST_END;
                end else begin
                    w_k_next     = r_k + W_K'(1);
                    w_state_next = ST_MEM_REQ;
                end
            end
            ST_END: begin
                if (r_valid && (r_tag == TAG_END)) begin
                    if (out_ready_i) begin
                        w_state_next = ST_DONE;
                    end
                end else if (w_take) begin
                    w_load    = 1'b1;
                    w_ld_tag  = TAG_END;
                    w_ld_data = W_OPR'(r_n_trace);
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_CAPTURE;
            end
        endcase
    end

    // Beat register, dump index and trace-length latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_tag     <= '0;
            r_idx     <= '0;
            r_reg     <= '0;
            r_data    <= '0;
            r_k       <= '0;
            r_n_trace <= '0;
        end else begin
            r_k <= w_k_next;
            if (w_load) begin
                r_valid <= 1'b1;
                r_tag   <= w_ld_tag;
                r_idx   <= w_ld_idx;
                r_reg   <= w_ld_reg;
                r_data  <= w_ld_data;
            end else if (r_valid && out_ready_i) begin
                r_valid <= 1'b0;
            end
            if ((r_state == ST_CAPTURE) && halt_i) begin
                r_n_trace <= w_n_trace;
            end
        end
    end

    assign reg_addr_o  = w_reg_addr;
    assign mem_addr_o  = w_mem_addr;
    assign out_valid_o = r_valid;
    assign out_tag_o   = r_tag;
    assign out_idx_o   = r_idx;
    assign out_reg_o   = r_reg;
    assign out_data_o  = r_data;
    assign busy_o      = (r_state == ST_TRACE) || (r_state == ST_REG) || (r_state == ST_MEM_REQ)
                      || (r_state == ST_MEM_WAIT) || (r_state == ST_END);
    assign done_o      = (r_state == ST_DONE);
    assign overflow_o  = w_ring_overflow;

endmodule

// File: tb/tb_trace_dump_unit.sv
// Bench for trace_dump_unit: a queue-based model of the expected beat stream,
// a per-cycle compare process, and literal expectations for the directed runs.
module tb_trace_dump_unit;
    localparam int DEPTH     = 16;
    localparam int N_REG     = 16;
    localparam int MEM_WORDS = 16;
    localparam int MEM_BASE  = 0;

    typedef struct packed {
        logic [1:0]  tag;
        logic [15:0] idx;
        logic [4:0]  rg;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [15:0] pc;
        logic        wr;
        logic [3:0]  rg;
        logic [31:0] res;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_valid_i = 1'b0;
    logic        trace_wr_i = 1'b0;
    logic [3:0]  trace_reg_i = '0;
    logic [15:0] trace_pc_i = '0;
    logic [31:0] trace_result_i = '0;
    logic        halt_i = 1'b0;
    logic [3:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [1:0]  out_tag_o;
    logic [15:0] out_idx_o;
    logic [4:0]  out_reg_o;
    logic [31:0] out_data_o;
    logic        busy_o;
    logic        done_o;
    logic        overflow_o;

    int    total = 0;
    int    bad = 0;
    bit    mon_en = 1'b0;
    bit    exp_ovf = 1'b0;
    beat_t exp_q[$];
    beat_t got_q[$];
    ret_t  ret_q[$];
    logic [31:0] regs [16];
    logic [31:0] mem_q = '0;

    always #5 clk = ~clk;

    trace_dump_unit dut (
        .clk            (clk),
        .reset          (reset),
        .trace_valid_i  (trace_valid_i),
        .trace_wr_i     (trace_wr_i),
        .trace_reg_i    (trace_reg_i),
        .trace_pc_i     (trace_pc_i),
        .trace_result_i (trace_result_i),
        .halt_i         (halt_i),
        .reg_addr_o     (reg_addr_o),
        .reg_data_i     (reg_data_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_i     (mem_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_tag_o      (out_tag_o),
        .out_idx_o      (out_idx_o),
        .out_reg_o      (out_reg_o),
        .out_data_o     (out_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o)
    );

    // Data-memory contents as a fixed function of the word address
    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = a ^ 16'h5a3c;
        lo = a * 16'd37 + 16'h0101;
        return {hi, lo};
    endfunction

    // Register file reads combinationally; data memory reads one cycle later
    assign reg_data_i = regs[reg_addr_o];
    always @(posedge clk) mem_q <= mem_fn(mem_addr_o);
    assign mem_data_i = mem_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every accepted beat against the model, and stall stability
    beat_t held;
    bit    hold_pending = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = '{tag: out_tag_o, idx: out_idx_o, rg: out_reg_o, data: out_data_o};
        if (!mon_en) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("stall_valid", 64'(out_valid_o), 64'd1);
                chk("stall_beat", 64'(cur), 64'(held));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat actual tag=%0d idx=%0h data=%0h required=no beat", cur.tag, cur.idx, cur.data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tag", 64'(cur.tag), 64'(e.tag));
                    chk("beat_idx", 64'(cur.idx), 64'(e.idx));
                    chk("beat_reg", 64'(cur.rg), 64'(e.rg));
                    chk("beat_data", 64'(cur.data), 64'(e.data));
                    got_q.push_back(cur);
                    $display("beat tag=%0d idx=%04h reg=%02h data=%08h", cur.tag, cur.idx, cur.rg, cur.data);
                end
            end
            hold_pending = out_valid_o && !out_ready_i;
            held = cur;
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_data"}, 64'(out_data_o), 64'd0);
        chk({name, "_ctl"}, 64'({out_valid_o, out_tag_o, out_idx_o, out_reg_o, busy_o, done_o,
                                 overflow_o, reg_addr_o, mem_addr_o}), 64'd0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b0;
        trace_valid_i = 1'b0;
        halt_i = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        got_q.delete();
        ret_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic model_push(input logic [15:0] pc, input bit wr, input logic [3:0] rg, input logic [31:0] res);
        ret_q.push_back('{pc: pc, wr: wr, rg: rg, res: res});
        if (ret_q.size() > DEPTH) begin
            void'(ret_q.pop_front());
            exp_ovf = 1'b1;
        end
    endtask

    task automatic retire(input logic [15:0] pc, input bit wr, input logic [3:0] rg, input logic [31:0] res);
        trace_valid_i = 1'b1;
        trace_pc_i = pc;
        trace_wr_i = wr;
        trace_reg_i = rg;
        trace_result_i = res;
        model_push(pc, wr, rg, res);
        tick();
        trace_valid_i = 1'b0;
    endtask

    // Halt (optionally with a coinciding retirement) and derive the whole expected dump
    task automatic halt_run(input bit with_ret, input logic [15:0] pc, input bit wr,
                            input logic [3:0] rg, input logic [31:0] res);
        logic [15:0] a;
        if (with_ret) begin
            trace_valid_i = 1'b1;
            trace_pc_i = pc;
            trace_wr_i = wr;
            trace_reg_i = rg;
            trace_result_i = res;
            model_push(pc, wr, rg, res);
        end
        foreach (ret_q[i]) exp_q.push_back('{tag: 2'b00, idx: ret_q[i].pc, rg: {ret_q[i].wr, ret_q[i].rg}, data: ret_q[i].res});
        for (int i = 0; i < N_REG; i++) exp_q.push_back('{tag: 2'b01, idx: 16'(i), rg: 5'd0, data: regs[i]});
        for (int k = 0; k < MEM_WORDS; k++) begin
            a = 16'(MEM_BASE + k);
            exp_q.push_back('{tag: 2'b10, idx: a, rg: 5'd0, data: mem_fn(a)});
        end
        exp_q.push_back('{tag: 2'b11, idx: 16'd0, rg: 5'd0, data: 32'(ret_q.size())});
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        trace_valid_i = 1'b0;
    endtask

    // Drain the dump with ready asserted pct% of cycles while spraying ignored retire/halt pulses
    task automatic run_dump(input int pct);
        int n;
        n = 0;
        while (!done_o && n < 3000) begin
            out_ready_i = ($urandom_range(99) < pct);
            trace_valid_i = ($urandom_range(3) == 0);
            trace_pc_i = 16'($urandom);
            trace_wr_i = 1'($urandom);
            trace_reg_i = 4'($urandom);
            trace_result_i = $urandom;
            halt_i = ($urandom_range(7) == 0);
            tick();
            n++;
        end
        out_ready_i = 1'b0;
        trace_valid_i = 1'b0;
        halt_i = 1'b0;
        chk("dump_in_budget", 64'(n < 3000), 64'd1);
        chk("busy_after_done", 64'(busy_o), 64'd0);
        chk("overflow", 64'(overflow_o), 64'(exp_ovf));
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        repeat (3) begin
            out_ready_i = 1'(($urandom));
            halt_i = 1'(($urandom));
            tick();
        end
        halt_i = 1'b0;
        chk("done_held", 64'(done_o), 64'd1);
        chk("idle_valid", 64'(out_valid_o), 64'd0);
    endtask

    function automatic logic [31:0] end_data();
        return got_q[got_q.size()-1].data;
    endfunction

    initial begin
        int n;
        int nmem;
        bit found;

        // Reset state
        do_reset();
        check_zero("reset");

        // Three retirements, constant ready
        retire(16'd0, 1'b1, 4'd1, 32'd5);
        retire(16'd1, 1'b1, 4'd2, 32'd7);
        retire(16'd2, 1'b0, 4'd0, 32'd0);
        halt_run(1'b0, '0, 1'b0, '0, '0);
        run_dump(100);
        chk("t1_count", 64'(got_q.size()), 64'd36);
        chk("t1_reg0", 64'(got_q[0].rg), 64'h11);
        chk("t1_reg1", 64'(got_q[1].rg), 64'h12);
        chk("t1_reg2", 64'(got_q[2].rg), 64'h00);
        chk("t1_first_mem_idx", 64'(got_q[19].idx), 64'd0);
        chk("t1_last_mem_idx", 64'(got_q[34].idx), 64'd15);
        chk("t1_end_data", 64'(end_data()), 64'd3);
        chk("t1_overflow", 64'(overflow_o), 64'd0);

        // Twenty retirements overflow a 16-entry trace
        do_reset();
        for (int i = 0; i < 20; i++) retire(16'(i), 1'b1, 4'(i), $urandom);
        halt_run(1'b0, '0, 1'b0, '0, '0);
        run_dump(100);
        chk("t2_overflow", 64'(overflow_o), 64'd1);
        chk("t2_first_pc", 64'(got_q[0].idx), 64'd4);
        chk("t2_last_pc", 64'(got_q[15].idx), 64'd19);
        chk("t2_after_trace_tag", 64'(got_q[16].tag), 64'd1);
        chk("t2_end_data", 64'(end_data()), 64'd16);

        // Halt with no retirements
        do_reset();
        halt_run(1'b0, '0, 1'b0, '0, '0);
        run_dump(60);
        chk("t3_first_tag", 64'(got_q[0].tag), 64'd1);
        chk("t3_first_idx", 64'(got_q[0].idx), 64'd0);
        chk("t3_end_data", 64'(end_data()), 64'd0);

        // Random retirement counts with ready toggling in every phase
        for (int r = 0; r < 5; r++) begin
            do_reset();
            n = $urandom_range(24);
            for (int i = 0; i < n; i++) retire(16'($urandom), 1'($urandom), 4'($urandom), $urandom);
            halt_run(1'b0, '0, 1'b0, '0, '0);
            run_dump(30 + 15 * r);
            nmem = 0;
            foreach (got_q[i]) if (got_q[i].tag == 2'b10) nmem++;
            chk("rand_mem_count", 64'(nmem), 64'd16);
        end

        // Reset in the middle of the memory phase
        do_reset();
        retire(16'h0040, 1'b1, 4'd3, 32'h1234);
        retire(16'h0041, 1'b1, 4'd4, 32'h5678);
        halt_run(1'b0, '0, 1'b0, '0, '0);
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            out_ready_i = 1'b1;
            tick();
            n++;
            if (busy_o && mem_addr_o == 16'd5) found = 1'b1;
        end
        chk("reach_mem_k5", 64'(found), 64'd1);
        chk("k5_busy", 64'(busy_o), 64'd1);
        mon_en = 1'b0;
        #1 reset = 1'b0;
        #1 check_zero("midreset");
        do_reset();
        retire(16'h0033, 1'b1, 4'd9, 32'hcafe_f00d);
        halt_run(1'b0, '0, 1'b0, '0, '0);
        run_dump(70);
        chk("t5_first_pc", 64'(got_q[0].idx), 64'h33);
        chk("t5_second_tag", 64'(got_q[1].tag), 64'd1);
        chk("t5_end_data", 64'(end_data()), 64'd1);

        // Retirement coinciding with halt
        do_reset();
        retire(16'd7, 1'b1, 4'd1, 32'd70);
        retire(16'd8, 1'b1, 4'd2, 32'd80);
        halt_run(1'b1, 16'd9, 1'b1, 4'd3, 32'd90);
        run_dump(80);
        chk("t6_last_trace_pc", 64'(got_q[2].idx), 64'd9);
        chk("t6_after_trace_tag", 64'(got_q[3].tag), 64'd1);
        chk("t6_end_data", 64'(end_data()), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
